// File: rtl/regf_wb_arbiter_if.sv
// Writeback-port bundle between the pipeline, the MDU result path and the register file.
// Latency: none (wires only).
// Backpressure: mdu_ready throttles the MDU; pipe_stall holds the pipeline's writeback.
//
// Signals:
//   pipe_we / pipe_rd_s / pipe_rd_v      writeback-stage write request
//   mdu_valid / mdu_rd_s / mdu_rd_v      MDU result offer, accepted with mdu_ready
//   pipe_stall                           writeback slot taken by the MDU buffer this cycle
//   wr_en / rd_s / rd_v                  register-file write port
// Modports: slave = arbiter side, master = pipeline/MDU/regfile side.
interface regf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd_s;
  logic [31:0] pipe_rd_v;
  logic        mdu_valid;
  logic [4:0]  mdu_rd_s;
  logic [31:0] mdu_rd_v;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        wr_en;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  modport slave (
    input  pipe_we, pipe_rd_s, pipe_rd_v,
    input  mdu_valid, mdu_rd_s, mdu_rd_v,
    output mdu_ready, pipe_stall,
    output wr_en, rd_s, rd_v
  );

  modport master (
    output pipe_we, pipe_rd_s, pipe_rd_v,
    output mdu_valid, mdu_rd_s, mdu_rd_v,
    input  mdu_ready, pipe_stall,
    input  wr_en, rd_s, rd_v
  );
endinterface

// File: rtl/regf_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and buffered MDU results.
// Latency: pipeline writes 0 cycles; MDU results >= 1 cycle (0 with WB_ARB_BYPASS_EN when idle).
// Backpressure: mdu_ready low when the buffer is full; pipe_stall for one cycle when a result starves.
//
// Ports: clk, rst (async active-high), bus (regf_wb_arbiter_if.slave).
// Parameters: DEPTH (buffer entries, power of two >= 2), STARVE_LIMIT (wait cycles before a forced stall).
// Optional feature: define WB_ARB_BYPASS_EN to let an MDU result write straight through when the
// buffer is empty and the pipeline is not writing.
module regf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  regf_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_PIPE  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       ent_rd_s_q [DEPTH];
  logic [4:0]       ent_rd_s_d [DEPTH];
  logic [31:0]      ent_rd_v_q [DEPTH];
  logic [31:0]      ent_rd_v_d [DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic        accept_ok;
  logic        pipe_wr;
  logic        force_drain;
  logic        kill;
  logic        drain;
  logic        enq;
  logic        bypass;
  logic        head_live;
  logic [4:0]  head_rd_s;
  logic [31:0] head_rd_v;

  logic        wr_en_c;
  logic [4:0]  rd_s_c;
  logic [31:0] rd_v_c;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // Registered count only: a dequeue in the same cycle does not reopen a full buffer.
  assign accept_ok  = !rst && !fifo_full;

  // A pipeline write to x0 is a no-op and never claims the port.
  assign pipe_wr     = bus.pipe_we && (bus.pipe_rd_s != 5'd0);
  assign force_drain = (state_q == ST_FORCE);
  // Only a write that actually lands (not stalled) makes older buffered results stale.
  assign kill        = pipe_wr && !force_drain;
  assign drain       = !fifo_empty && (force_drain || !pipe_wr);

  assign head_live = live_q[head_q];
  assign head_rd_s = ent_rd_s_q[head_q];
  assign head_rd_v = ent_rd_v_q[head_q];

`ifdef WB_ARB_BYPASS_EN
  assign bypass = fifo_empty && bus.mdu_valid && (bus.mdu_rd_s != 5'd0) && !pipe_wr && accept_ok;
`else
  assign bypass = 1'b0;
`endif

  // Results to x0 are handshaken but never stored.
  assign enq = bus.mdu_valid && accept_ok && (bus.mdu_rd_s != 5'd0) && !bypass;

  // Write-port mux. drain already excludes the case where the pipeline owns the port in PIPE.
  always_comb begin
    wr_en_c = 1'b0;
    rd_s_c  = 5'd0;
    rd_v_c  = 32'd0;
    if (!rst) begin
      if (drain) begin
        // A killed head is popped silently.
        if (head_live) begin
          wr_en_c = 1'b1;
          rd_s_c  = head_rd_s;
          rd_v_c  = head_rd_v;
        end
      end else if (pipe_wr) begin
        wr_en_c = 1'b1;
        rd_s_c  = bus.pipe_rd_s;
        rd_v_c  = bus.pipe_rd_v;
      end else if (bypass) begin
        wr_en_c = 1'b1;
        rd_s_c  = bus.mdu_rd_s;
        rd_v_c  = bus.mdu_rd_v;
      end
    end
  end

  assign bus.wr_en      = wr_en_c;
  assign bus.rd_s       = rd_s_c;
  assign bus.rd_v       = rd_v_c;
  assign bus.pipe_stall = !rst && force_drain;
  assign bus.mdu_ready  = accept_ok;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    live_d       = live_q;
    ent_rd_s_d   = ent_rd_s_q;
    ent_rd_v_d   = ent_rd_v_q;
    starve_cnt_d = starve_cnt_q;
    state_d      = state_q;

    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_rd_s_q[i] == bus.pipe_rd_s) begin
          live_d[i] = 1'b0;
        end
      end
    end

    if (drain) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end

    // Enqueue cannot alias the draining slot: it needs a non-full buffer, and the
    // head only drains from a non-empty one, so tail != head whenever both happen.
    if (enq) begin
      ent_rd_s_d[tail_q] = bus.mdu_rd_s;
      ent_rd_v_d[tail_q] = bus.mdu_rd_v;
      live_d[tail_q]     = !(kill && (bus.mdu_rd_s == bus.pipe_rd_s));
      tail_d             = tail_q + PTR_W'(1);
    end

    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || drain) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STV_MAX) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end

    // Entering FORCE on the cycle the counter reaches the limit puts the stall exactly
    // STARVE_LIMIT+1 cycles after the enqueue; FORCE always drains, so it lasts one cycle.
    if (force_drain) begin
      state_d = ST_PIPE;
    end else if (starve_cnt_d == STV_MAX) begin
      state_d = ST_FORCE;
    end else begin
      state_d = ST_PIPE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PIPE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      live_q       <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      live_q       <= live_d;
    end
  end

  // Payload storage needs no reset: live bits and count gate every use of it.
  always_ff @(posedge clk) begin
    ent_rd_s_q <= ent_rd_s_d;
    ent_rd_v_q <= ent_rd_v_d;
  end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
module tb_regf_wb_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;

  regf_wb_arbiter_if bus ();

  regf_wb_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic [4:0]  rs;
    logic [31:0] v;
  } wr_exp_t;

  wr_exp_t     wq [$];
  int          sq [$];
  wr_exp_t     mon_e;
  int          mon_s;
  logic [31:0] regs [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] ps, input logic [31:0] pv,
                       input logic mv, input logic [4:0] ms, input logic [31:0] mval);
    bus.pipe_we   = pw;
    bus.pipe_rd_s = ps;
    bus.pipe_rd_v = pv;
    bus.mdu_valid = mv;
    bus.mdu_rd_s  = ms;
    bus.mdu_rd_v  = mval;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] rs, input logic [31:0] v);
    wr_exp_t e;
    e.cyc = cyc;
    e.rs  = rs;
    e.v   = v;
    wq.push_back(e);
  endtask

  task automatic exp_stall();
    sq.push_back(cyc);
  endtask

  // Monitor: every write and every stall pulse must match the next expected record.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      regs[bus.rd_s] = bus.rd_v;
      chk("wr_rd_s_nonzero", 32'(bus.rd_s != 5'd0), 32'd1);
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd_s=%0d rd_v=0x%0h at cycle %0d, expected no write",
                 bus.rd_s, bus.rd_v, cyc);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_rd_s", 32'(bus.rd_s), 32'(mon_e.rs));
        chk("wr_rd_v", bus.rd_v, mon_e.v);
      end
    end else begin
      chk("idle_port_zero", 32'((bus.rd_s == 5'd0) && (bus.rd_v == 32'd0)), 32'd1);
    end
    if (bus.pipe_stall === 1'b1) begin
      if (sq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_stall: got pipe_stall=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_s = sq.pop_front();
        chk("stall_cycle", cyc, mon_s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst = 1'b1;
    idle();

    // Reset: outputs idle even with a pipeline write requested.
    step();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    step();
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    step();

    // Idle pipeline, single MDU result.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef WB_ARB_BYPASS_EN
    exp_wr(5'd5, 32'hDEADBEEF);
`endif
    #2;
    chk("t1_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    step();
    idle();
`ifndef WB_ARB_BYPASS_EN
    exp_wr(5'd5, 32'hDEADBEEF);
`endif
    step();
    step();

    // Plain pipeline write, zero latency.
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd3, 32'h33);
    step();
    idle();
    step();

    // x0 from both sources: handshake accepted, nothing written, nothing buffered.
    drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h55);
    #2;
    chk("x0_wr_en", 32'(bus.wr_en), 32'd0);
    chk("x0_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    step();
    idle();
    #2;
    chk("x0_no_drain", 32'(bus.wr_en), 32'd0);
    step();

    // Fill while the pipeline holds the port, then forced stall on starvation.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA);
    exp_wr(5'd1, 32'h100);
    step();
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd11, 32'hB);
    exp_wr(5'd1, 32'h100);
    #2;
    chk("fill_ready_second", 32'(bus.mdu_ready), 32'd1);
    step();
    drive(1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      exp_wr(5'd1, 32'h100);
      #2;
      chk("fill_ready_low", 32'(bus.mdu_ready), 32'd0);
      chk("fill_no_stall", 32'(bus.pipe_stall), 32'd0);
      step();
    end
    // Fifth cycle after the first enqueue: stall, oldest entry written.
    exp_stall();
    exp_wr(5'd10, 32'hA);
    #2;
    chk("force_stall", 32'(bus.pipe_stall), 32'd1);
    step();
    idle();
    exp_wr(5'd11, 32'hB);
    #2;
    chk("after_force_ready", 32'(bus.mdu_ready), 32'd1);
    chk("after_force_no_stall", 32'(bus.pipe_stall), 32'd0);
    step();
    step();

    // WAW kill of a buffered entry.
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd7, 32'h11);
    exp_wr(5'd2, 32'h200);
    step();
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    exp_wr(5'd7, 32'h22);
    step();
    idle();
    #2;
    chk("waw_dead_drain", 32'(bus.wr_en), 32'd0);
    step();
    // WAW kill of an entry enqueued in the same cycle.
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'h77);
    exp_wr(5'd8, 32'h88);
    step();
    idle();
    #2;
    chk("waw_same_cycle_dead", 32'(bus.wr_en), 32'd0);
    step();
    #2;
    chk("waw_buffer_empty_ready", 32'(bus.mdu_ready), 32'd1);
    step();

    // Back-to-back results with an idle pipeline: order kept, count steady.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20);
`ifdef WB_ARB_BYPASS_EN
    exp_wr(5'd20, 32'h20);
`endif
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h21);
`ifdef WB_ARB_BYPASS_EN
    exp_wr(5'd21, 32'h21);
`else
    exp_wr(5'd20, 32'h20);
`endif
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h22);
`ifdef WB_ARB_BYPASS_EN
    exp_wr(5'd22, 32'h22);
`else
    exp_wr(5'd21, 32'h21);
`endif
    #2;
    chk("stream_ready", 32'(bus.mdu_ready), 32'd1);
    step();
    idle();
`ifndef WB_ARB_BYPASS_EN
    exp_wr(5'd22, 32'h22);
`endif
    step();
    step();

    // Reset with two entries buffered.
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hC);
    exp_wr(5'd4, 32'h400);
    step();
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd13, 32'hD);
    exp_wr(5'd4, 32'h400);
    step();
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd14, 32'hE);
    rst = 1'b1;
    #2;
    chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("midrst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    chk("midrst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    step();
    idle();
    step();
    rst = 1'b0;
    #2;
    chk("postrst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    chk("postrst_wr_en", 32'(bus.wr_en), 32'd0);
    for (int k = 0; k < 6; k++) step();

    // Final state.
    chk("reg7_value", regs[7], 32'h22);
    chk("reg8_value", regs[8], 32'h88);
    chk("reg5_value", regs[5], 32'hDEADBEEF);
    chk("reg0_untouched", regs[0], 32'd0);
    chk("pending_writes", wq.size(), 32'd0);
    chk("pending_stalls", sq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regf_wb_arbiter.md
REGF_WB_ARBITER -- requirements
Module: regf_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, number of MDU result buffer entries; power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive cycles a buffered result may wait before forcing a pipeline stall.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 Pipeline ports: pipe_we input 1, writeback stage requests a write; pipe_rd_s input 5, destination register; pipe_rd_v input 32, write data.
REQ-005 MDU ports: mdu_valid input 1, result offered; mdu_rd_s input 5, destination register; mdu_rd_v input 32, result value; mdu_ready output 1, result accepted when high together with mdu_valid.
REQ-006 Pipeline control: pipe_stall output 1, writeback slot taken by the buffer this cycle; pipeline holds its writeback instruction.
REQ-007 Register file port: wr_en output 1, write enable; rd_s output 5, destination register; rd_v output 32, write data.

Function
REQ-008 Regfile outputs SHALL be combinational from the current inputs and registered state; pipeline writes have 0-cycle latency.
REQ-009 Buffer: DEPTH-entry circular FIFO of {rd_s, rd_v, live}, with wrap-around head and tail pointers and a count register.
REQ-010 mdu_ready = (count < DEPTH), computed from registered count only; no enqueue when full even if the same cycle dequeues.
REQ-011 Enqueue on mdu_valid & mdu_ready; results with mdu_rd_s == 0 are accepted and discarded.
REQ-012 Arbitration states: PIPE (default) and FORCE. PIPE: the pipeline owns the port when pipe_we & pipe_rd_s != 0; otherwise the FIFO head drains.
REQ-013 starve_cnt increments each cycle the FIFO is non-empty and the head does not drain; it clears on drain or when the FIFO is empty; it saturates at STARVE_LIMIT.
REQ-014 When starve_cnt == STARVE_LIMIT, the state moves to FORCE. In FORCE, pipe_stall = 1, the head drains, and the state returns to PIPE next cycle. Exactly one stall cycle per starvation event.
REQ-015 A dequeue of an entry with live == 0 SHALL pop the entry without asserting wr_en.
REQ-016 WAW kill: a pipeline write (pipe_we & !pipe_stall) to rd_s == R SHALL clear live on every FIFO entry with rd_s == R in that cycle, including an entry being enqueued that cycle.
REQ-017 wr_en SHALL never be asserted with rd_s == 0; when nothing writes, rd_s = 0 and rd_v = 0.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged; FIFO order is strictly preserved.

Reset
REQ-019 rst SHALL asynchronously set count, head, tail and starve_cnt to 0 and the state to PIPE, and clear all live bits.
REQ-020 While rst is high: wr_en = 0, pipe_stall = 0, mdu_ready = 0.
REQ-021 An in-flight MDU handshake coincident with rst is dropped; buffered results are lost.

Configuration
REQ-022 Macro WB_ARB_BYPASS_EN, when defined:
- Condition: FIFO empty, mdu_valid, mdu_rd_s != 0, and the pipeline not writing.
- Action: the MDU result drives the regfile port directly in the same cycle and is not enqueued.
REQ-023 Without WB_ARB_BYPASS_EN, every accepted result is enqueued; its earliest write is the following cycle.

Verification
REQ-024 Idle pipeline, mdu_valid with rd_s=5, rd_v=0xDEADBEEF:
- Without the macro: wr_en with rd_s=5 one cycle later.
- With the macro: wr_en in the same cycle.
REQ-025 Fill: 2 back-to-back MDU results while pipe_we is held with rd_s=1 -> mdu_ready low on the third cycle; count = 2.
REQ-026 Starvation: pipe_we held continuously with one buffered entry -> pipe_stall pulses for exactly 1 cycle, 5 cycles after the enqueue (STARVE_LIMIT=4), and the entry is written that cycle.
REQ-027 WAW kill: buffer rd_s=7 value 0x11, then pipeline writes rd_s=7 value 0x22 -> the entry drains with wr_en low; the register holds 0x22.
REQ-028 Reset mid-operation: rst asserted with 2 entries buffered -> outputs idle immediately; after release, mdu_ready = 1 and no stale write occurs.
REQ-029 x0: an MDU result or pipeline write to rd_s=0 -> wr_en never asserted.
